// File: rtl/n64_pkg.sv
// Shared definitions for the multi-channel N64 poll controller: register
// offsets, CTRL/STATUS bit positions and the scheduler state encoding.
package n64_pkg;

    localparam logic [7:0] ADDR_CTRL      = 8'h00;
    localparam logic [7:0] ADDR_PERIOD    = 8'h04;
    localparam logic [7:0] ADDR_STATUS    = 8'h08;
    localparam logic [7:0] ADDR_IRQ_EN    = 8'h0C;
    localparam logic [7:0] ADDR_DATA_BASE = 8'h10;

    localparam int CTRL_EN_BIT   = 0;
    localparam int CTRL_RST_BIT  = 1;
    localparam int CTRL_MASK_LSB = 8;

    localparam int ST_NEW_LSB = 0;
    localparam int ST_ERR_LSB = 8;
    localparam int ST_OVR_BIT = 31;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        ISSUE,
        WAIT
    } sched_state_e;

endpackage

// File: rtl/n64_poll_sched.sv
// Period timer plus sweep scheduler: walks the masked channels in ascending
// order, one outstanding poll at a time, with a per-poll timeout.
module n64_poll_sched
    import n64_pkg::*;
#(
    parameter int          NUM_CH      = 4,
    parameter logic [15:0] TIMEOUT_CYC = 16'd20000
) (
    input  logic                          clk,
    input  logic                          srst,
    input  logic                          enable_i,
    input  logic [NUM_CH-1:0]             mask_i,
    input  logic [31:0]                   period_i,
    input  logic                          period_wr_i,
    input  logic [NUM_CH-1:0]             poll_done_i,
    input  logic [NUM_CH-1:0]             poll_err_i,
    output logic [NUM_CH-1:0]             poll_req_o,
    output logic                          capture_o,
    output logic                          error_o,
    output logic                          overrun_o,
    output logic [$clog2(NUM_CH+1)-1:0]   index_o
);
    localparam int IW = $clog2(NUM_CH + 1);

    sched_state_e      state_q;
    logic [31:0]       timer_q;
    logic [15:0]       tmo_q;
    logic [IW-1:0]     idx_q;
    logic [NUM_CH-1:0] req_q;

    logic              tick;
    logic              found;
    logic [IW-1:0]     next_idx;
    logic [NUM_CH-1:0] req_d;
    logic              done_sel;
    logic              err_sel;
    logic              wait_done;
    logic              tmo_hit;

    assign tick = enable_i && (period_i != 32'd0) && (timer_q == period_i - 32'd1);

    always_comb begin
        found    = 1'b0;
        next_idx = '0;
        req_d    = '0;
        done_sel = 1'b0;
        err_sel  = 1'b0;
        // Descending walk so the lowest eligible channel is the one that sticks.
        for (int c = NUM_CH - 1; c >= 0; c--) begin
            if (mask_i[c] && (IW'(c) >= idx_q)) begin
                found    = 1'b1;
                next_idx = IW'(c);
            end
        end
        for (int c = 0; c < NUM_CH; c++) begin
            req_d[c] = (next_idx == IW'(c));
            if (idx_q == IW'(c)) begin
                done_sel = poll_done_i[c];
                err_sel  = poll_err_i[c];
            end
        end
    end

    assign wait_done = (state_q == WAIT) && done_sel;
    assign tmo_hit   = (state_q == WAIT) && !done_sel && ((tmo_q + 16'd1) == TIMEOUT_CYC);
    assign capture_o = wait_done && !err_sel;
    assign error_o   = (wait_done && err_sel) || tmo_hit;
    assign overrun_o = tick && (state_q != IDLE);
    assign index_o   = idx_q;
    assign poll_req_o = req_q;

    always_ff @(posedge clk) begin
        if (srst || period_wr_i || !enable_i || (period_i == 32'd0) || tick) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            tmo_q   <= '0;
            req_q   <= '0;
        end else begin
            req_q <= '0;
            case (state_q)
                IDLE: begin
                    if (tick) state_q <= SCAN;
                end
                SCAN: begin
                    if (found && enable_i) begin
                        idx_q   <= next_idx;
                        req_q   <= req_d;
                        state_q <= ISSUE;
                    end else begin
                        idx_q   <= '0;
                        state_q <= IDLE;
                    end
                end
                ISSUE: begin
                    tmo_q   <= '0;
                    state_q <= WAIT;
                end
                WAIT: begin
                    if (done_sel || tmo_hit) begin
                        idx_q   <= idx_q + 1'b1;
                        state_q <= SCAN;
                    end else begin
                        tmo_q <= tmo_q + 16'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/n64_multi_poll_ctrl.sv
// APB register bank, per-channel data latches, sticky status and irq for up to
// eight N64 serial engines. Define N64_CHANGE_DETECT_EN to flag only changed data.
module n64_multi_poll_ctrl
    import n64_pkg::*;
#(
    parameter int          NUM_CH         = 4,
    parameter logic [31:0] DEFAULT_PERIOD = 32'd100000,
    parameter logic [15:0] TIMEOUT_CYC    = 16'd20000
) (
    input  logic                   PCLK,
    input  logic                   PRESET,
    input  logic                   PSEL,
    input  logic                   PENABLE,
    input  logic                   PWRITE,
    input  logic [31:0]            PADDR,
    input  logic [31:0]            PWDATA,
    output logic [31:0]            PRDATA,
    output logic                   PREADY,
    output logic                   PSLVERR,
    input  logic [NUM_CH*32-1:0]   button_data,
    input  logic [NUM_CH-1:0]      poll_done,
    input  logic [NUM_CH-1:0]      poll_err,
    output logic [NUM_CH-1:0]      poll_req,
    output logic [NUM_CH-1:0]      controller_reset,
    output logic                   irq
);
    localparam int         IW       = $clog2(NUM_CH + 1);
    localparam logic [8:0] DATA_END = 9'(ADDR_DATA_BASE) + 9'(4 * NUM_CH);

    logic              en_q;
    logic [NUM_CH-1:0] mask_q;
    logic [31:0]       period_q;
    logic [NUM_CH-1:0] new_q, err_q, ien_new_q, ien_err_q, creset_q;
    logic              ovr_q, ien_ovr_q, irq_q;
    logic [31:0]       data_q [NUM_CH];

    logic [NUM_CH-1:0] new_d, err_d, new_set, err_set, w1c_new, w1c_err;
    logic              ovr_d;
    logic              capture, error_stb, overrun_stb;
    logic [IW-1:0]     index;

    logic [7:0]  addr;
    logic [5:0]  data_idx;
    logic        sel_ctrl, sel_period, sel_status, sel_irqen, sel_data, addr_ok;
    logic        wr_en, wr_ctrl, wr_period, wr_status, wr_irqen;
    logic [31:0] rd_data;
    logic        unused_bits;

    assign addr       = PADDR[7:0];
    assign data_idx   = addr[7:2] - 6'd4;
    assign sel_ctrl   = (addr == ADDR_CTRL);
    assign sel_period = (addr == ADDR_PERIOD);
    assign sel_status = (addr == ADDR_STATUS);
    assign sel_irqen  = (addr == ADDR_IRQ_EN);
    assign sel_data   = (addr >= ADDR_DATA_BASE) && ({1'b0, addr} < DATA_END) && (addr[1:0] == 2'b00);
    assign addr_ok    = sel_ctrl || sel_period || sel_status || sel_irqen || sel_data;

    assign wr_en      = PSEL && PENABLE && PWRITE;
    assign wr_ctrl    = wr_en && sel_ctrl;
    assign wr_period  = wr_en && sel_period;
    assign wr_status  = wr_en && sel_status;
    assign wr_irqen   = wr_en && sel_irqen;

    assign PREADY      = 1'b1;
    assign PSLVERR     = PSEL && PENABLE && !addr_ok;
    assign PRDATA      = PSEL ? rd_data : 32'd0;
    assign unused_bits = ^{PADDR[31:8], PWDATA};

    n64_poll_sched #(
        .NUM_CH      (NUM_CH),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_sched (
        .clk         (PCLK),
        .srst        (PRESET),
        .enable_i    (en_q),
        .mask_i      (mask_q),
        .period_i    (period_q),
        .period_wr_i (wr_period),
        .poll_done_i (poll_done),
        .poll_err_i  (poll_err),
        .poll_req_o  (poll_req),
        .capture_o   (capture),
        .error_o     (error_stb),
        .overrun_o   (overrun_stb),
        .index_o     (index)
    );

    always_comb begin
        rd_data = '0;
        if (sel_ctrl) begin
            rd_data[CTRL_EN_BIT]                = en_q;
            rd_data[CTRL_MASK_LSB +: NUM_CH]    = mask_q;
        end else if (sel_period) begin
            rd_data = period_q;
        end else if (sel_status) begin
            rd_data[ST_NEW_LSB +: NUM_CH] = new_q;
            rd_data[ST_ERR_LSB +: NUM_CH] = err_q;
            rd_data[ST_OVR_BIT]           = ovr_q;
        end else if (sel_irqen) begin
            rd_data[ST_NEW_LSB +: NUM_CH] = ien_new_q;
            rd_data[ST_ERR_LSB +: NUM_CH] = ien_err_q;
            rd_data[ST_OVR_BIT]           = ien_ovr_q;
        end else if (sel_data) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (data_idx == 6'(c)) rd_data = data_q[c];
            end
        end
    end

    always_comb begin
        new_set = '0;
        err_set = '0;
        for (int c = 0; c < NUM_CH; c++) begin
`ifdef N64_CHANGE_DETECT_EN
            new_set[c] = capture && (index == IW'(c)) && (button_data[c*32 +: 32] != data_q[c]);
`else
            new_set[c] = capture && (index == IW'(c));
`endif
            err_set[c] = error_stb && (index == IW'(c));
        end
        w1c_new = wr_status ? PWDATA[ST_NEW_LSB +: NUM_CH] : '0;
        w1c_err = wr_status ? PWDATA[ST_ERR_LSB +: NUM_CH] : '0;
        // Hardware set is OR-ed in after the clear so a coincident event is never lost.
        new_d   = (new_q & ~w1c_new) | new_set;
        err_d   = (err_q & ~w1c_err) | err_set;
        ovr_d   = (ovr_q & ~(wr_status && PWDATA[ST_OVR_BIT])) | overrun_stb;
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            en_q      <= 1'b0;
            mask_q    <= '0;
            period_q  <= DEFAULT_PERIOD;
            new_q     <= '0;
            err_q     <= '0;
            ovr_q     <= 1'b0;
            ien_new_q <= '0;
            ien_err_q <= '0;
            ien_ovr_q <= 1'b0;
            creset_q  <= '0;
            irq_q     <= 1'b0;
            for (int c = 0; c < NUM_CH; c++) data_q[c] <= '0;
        end else begin
            new_q    <= new_d;
            err_q    <= err_d;
            ovr_q    <= ovr_d;
            irq_q    <= (|(new_q & ien_new_q)) | (|(err_q & ien_err_q)) | (ovr_q & ien_ovr_q);
            creset_q <= (wr_ctrl && PWDATA[CTRL_RST_BIT]) ? PWDATA[CTRL_MASK_LSB +: NUM_CH] : '0;
            if (wr_ctrl) begin
                en_q   <= PWDATA[CTRL_EN_BIT];
                mask_q <= PWDATA[CTRL_MASK_LSB +: NUM_CH];
            end
            if (wr_period) period_q <= PWDATA;
            if (wr_irqen) begin
                ien_new_q <= PWDATA[ST_NEW_LSB +: NUM_CH];
                ien_err_q <= PWDATA[ST_ERR_LSB +: NUM_CH];
                ien_ovr_q <= PWDATA[ST_OVR_BIT];
            end
            for (int c = 0; c < NUM_CH; c++) begin
                if (capture && (index == IW'(c))) data_q[c] <= button_data[c*32 +: 32];
            end
        end
    end

    assign controller_reset = creset_q;
    assign irq              = irq_q;

endmodule

// File: tb/tb_n64_multi_poll_ctrl.sv
// Directed bench for n64_multi_poll_ctrl: a behavioural controller model answers
// poll requests; each scenario task checks registers, pulses and timing.
`timescale 1ns/1ps
module tb_n64_multi_poll_ctrl;
    localparam int NC = 4;

    logic              PCLK = 1'b0;
    logic              PRESET = 1'b1;
    logic              PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
    logic [31:0]       PADDR = '0, PWDATA = '0;
    logic [31:0]       PRDATA;
    logic              PREADY, PSLVERR;
    logic [NC*32-1:0]  button_data = '0;
    logic [NC-1:0]     poll_done = '0, poll_err = '0;
    logic [NC-1:0]     poll_req, controller_reset;
    logic              irq;

    int errors = 0;
    int checks = 0;

    int          resp_delay [NC];
    logic [31:0] resp_data  [NC];
    bit          resp_en    [NC];
    bit          resp_err   [NC];

    int          cyc = 0;
    int          cnt [NC] = '{default: 0};
    bit          pending [NC] = '{default: 0};
    int          req_count [NC] = '{default: 0};
    int          last_req_cyc [NC] = '{default: 0};
    int          overlaps = 0;
    int          creset_cycles = 0;
    logic [NC-1:0] creset_seen = '0;
    int          irq_rise_cyc = -1;
    logic        irq_prev = 1'b0;

    n64_multi_poll_ctrl #(
        .NUM_CH         (NC),
        .DEFAULT_PERIOD (32'd100000),
        .TIMEOUT_CYC    (16'd50)
    ) dut (
        .PCLK             (PCLK),
        .PRESET           (PRESET),
        .PSEL             (PSEL),
        .PENABLE          (PENABLE),
        .PWRITE           (PWRITE),
        .PADDR            (PADDR),
        .PWDATA           (PWDATA),
        .PRDATA           (PRDATA),
        .PREADY           (PREADY),
        .PSLVERR          (PSLVERR),
        .button_data      (button_data),
        .poll_done        (poll_done),
        .poll_err         (poll_err),
        .poll_req         (poll_req),
        .controller_reset (controller_reset),
        .irq              (irq)
    );

    always #5 PCLK = ~PCLK;
    always @(posedge PCLK) cyc <= cyc + 1;

    // Controller model plus passive monitors, all sampled on the falling edge.
    always @(negedge PCLK) begin
        if ($countones(poll_req) > 1) overlaps++;
        for (int c = 0; c < NC; c++) begin
            poll_done[c] = 1'b0;
            poll_err[c]  = 1'b0;
            if (poll_req[c]) begin
                for (int k = 0; k < NC; k++) if (pending[k]) overlaps++;
                req_count[c]++;
                last_req_cyc[c] = cyc;
                if (resp_en[c]) begin
                    pending[c] = 1'b1;
                    cnt[c]     = resp_delay[c];
                end
            end else if (cnt[c] > 0) begin
                cnt[c]--;
                if (cnt[c] == 0) begin
                    poll_done[c] = 1'b1;
                    poll_err[c]  = resp_err[c];
                    button_data[c*32 +: 32] = resp_data[c];
                    pending[c] = 1'b0;
                end
            end
        end
        if (controller_reset != '0) begin
            creset_cycles++;
            creset_seen = controller_reset;
        end
        if (irq && !irq_prev) irq_rise_cyc = cyc;
        irq_prev = irq;
    end

    task automatic apb_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge PCLK);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = a; PWDATA = d;
        @(negedge PCLK);
        PENABLE = 1'b1;
        @(negedge PCLK);
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        $display("apb write addr=%h data=%h", a, d);
    endtask

    task automatic apb_read(input logic [31:0] a, output logic [31:0] d, output logic e);
        @(negedge PCLK);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = a;
        @(negedge PCLK);
        PENABLE = 1'b1;
        #1;
        d = PRDATA;
        e = PSLVERR;
        @(negedge PCLK);
        PSEL = 1'b0; PENABLE = 1'b0;
        $display("apb read  addr=%h data=%h slverr=%b", a, d, e);
    endtask

    task automatic wait_reqs(input int c, input int target, input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge PCLK);
            if (req_count[c] >= target) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic do_reset();
        PRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        repeat (3) @(negedge PCLK);
        PRESET = 1'b0;
    endtask

    task automatic model_default();
        for (int c = 0; c < NC; c++) begin
            resp_delay[c] = 10;
            resp_data[c]  = 32'hC0DE_0000 + 32'(c);
            resp_en[c]    = 1'b1;
            resp_err[c]   = 1'b0;
        end
    endtask

    task automatic test_reset();
        logic [31:0] addrs [6] = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h1C};
        logic [31:0] exps  [6] = '{32'h0, 32'd100000, 32'h0, 32'h0, 32'h0, 32'h0};
        logic [31:0] d;
        logic        e;
        do_reset();
        #1;
        checks++;
        if (PREADY !== 1'b1 || PSLVERR !== 1'b0 || PRDATA !== 32'h0) begin
            errors++;
            $display("FAIL reset_apb: pready=%b pslverr=%b prdata=%h required 1 0 0", PREADY, PSLVERR, PRDATA);
        end
        checks++;
        if (poll_req !== '0 || controller_reset !== '0 || irq !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: poll_req=%h creset=%h irq=%b required 0 0 0", poll_req, controller_reset, irq);
        end
        for (int i = 0; i < 6; i++) begin
            apb_read(addrs[i], d, e);
            checks++;
            if (d !== exps[i] || e !== 1'b0) begin
                errors++;
                $display("FAIL reset_reg_%h: read %h err %b required %h err 0", addrs[i], d, e, exps[i]);
            end
        end
    endtask

    task automatic test_sweep();
        int          snap [NC];
        bit          ok;
        logic [31:0] d;
        logic        e;
        do_reset();
        model_default();
        resp_data[0] = 32'hA5A5_0001;
        resp_data[2] = 32'h0000_00FF;
        for (int c = 0; c < NC; c++) snap[c] = req_count[c];
        apb_write(32'h04, 32'd100);
        apb_write(32'h00, 32'h0000_0501);
        wait_reqs(2, snap[2] + 1, 400, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL sweep_wait: poll_req[2] seen=0 required 1");
        end
        repeat (20) @(negedge PCLK);
        apb_write(32'h00, 32'h0000_0500);
        checks++;
        if (req_count[0] - snap[0] != 1 || req_count[1] - snap[1] != 0 ||
            req_count[2] - snap[2] != 1 || req_count[3] - snap[3] != 0) begin
            errors++;
            $display("FAIL sweep_reqs: counts %0d %0d %0d %0d required 1 0 1 0",
                     req_count[0] - snap[0], req_count[1] - snap[1],
                     req_count[2] - snap[2], req_count[3] - snap[3]);
        end
        checks++;
        if (last_req_cyc[2] - last_req_cyc[0] != 12) begin
            errors++;
            $display("FAIL sweep_spacing: req2-req0=%0d cycles required 12", last_req_cyc[2] - last_req_cyc[0]);
        end
        apb_read(32'h10, d, e);
        checks++;
        if (d !== 32'hA5A5_0001) begin
            errors++;
            $display("FAIL sweep_data0: read %h required a5a50001", d);
        end
        apb_read(32'h18, d, e);
        checks++;
        if (d !== 32'h0000_00FF) begin
            errors++;
            $display("FAIL sweep_data2: read %h required 000000ff", d);
        end
        apb_read(32'h14, d, e);
        checks++;
        if (d !== 32'h0) begin
            errors++;
            $display("FAIL sweep_data1: read %h required 00000000", d);
        end
        apb_read(32'h08, d, e);
        checks++;
        if (d !== 32'h0000_0005) begin
            errors++;
            $display("FAIL sweep_status: read %h required 00000005", d);
        end
    endtask

    task automatic test_timeout();
        int          snap0, snap2, rise_snap, r0;
        bit          ok;
        logic [31:0] d;
        logic        e;
        do_reset();
        model_default();
        resp_en[0] = 1'b0;
        snap0 = req_count[0];
        snap2 = req_count[2];
        rise_snap = irq_rise_cyc;
        apb_write(32'h0C, 32'h0000_0100);
        apb_write(32'h04, 32'd100);
        apb_write(32'h00, 32'h0000_0501);
        wait_reqs(2, snap2 + 1, 500, ok);
        checks++;
        if (!ok || req_count[0] - snap0 != 1) begin
            errors++;
            $display("FAIL timeout_wait: ch2_polled=%b ch0_reqs=%0d required 1 1", ok, req_count[0] - snap0);
        end
        repeat (20) @(negedge PCLK);
        apb_write(32'h00, 32'h0000_0500);
        r0 = last_req_cyc[0];
        checks++;
        if (last_req_cyc[2] - r0 < 50 || last_req_cyc[2] - r0 > 54) begin
            errors++;
            $display("FAIL timeout_next_req: req2-req0=%0d cycles required 50..54", last_req_cyc[2] - r0);
        end
        checks++;
        if (irq_rise_cyc == rise_snap || irq_rise_cyc - r0 < 50 || irq_rise_cyc - r0 > 54) begin
            errors++;
            $display("FAIL timeout_irq_time: irq rise at req0+%0d required 50..54", irq_rise_cyc - r0);
        end
        apb_read(32'h08, d, e);
        checks++;
        if (d !== 32'h0000_0104 || irq !== 1'b1) begin
            errors++;
            $display("FAIL timeout_status: status %h irq %b required 00000104 irq 1", d, irq);
        end
        apb_write(32'h08, 32'h0000_0104);
        repeat (3) @(negedge PCLK);
        apb_read(32'h08, d, e);
        checks++;
        if (d !== 32'h0 || irq !== 1'b0) begin
            errors++;
            $display("FAIL timeout_clear: status %h irq %b required 00000000 irq 0", d, irq);
        end
        resp_en[0] = 1'b1;
    endtask

    task automatic test_overrun();
        int          snap_ov, snap0;
        logic [31:0] d;
        logic        e;
        do_reset();
        model_default();
        resp_delay[0] = 20;
        snap_ov = overlaps;
        snap0   = req_count[0];
        apb_write(32'h04, 32'd5);
        apb_write(32'h00, 32'h0000_0101);
        repeat (80) @(negedge PCLK);
        apb_write(32'h00, 32'h0000_0100);
        repeat (30) @(negedge PCLK);
        apb_read(32'h08, d, e);
        checks++;
        if (d[31] !== 1'b1) begin
            errors++;
            $display("FAIL overrun_bit: status %h bit31=%b required 1", d, d[31]);
        end
        checks++;
        if (overlaps != snap_ov || req_count[0] - snap0 < 2) begin
            errors++;
            $display("FAIL overrun_reqs: overlaps=%0d reqs=%0d required 0 and >=2", overlaps - snap_ov, req_count[0] - snap0);
        end
    endtask

    task automatic test_w1c_collision();
        bit          seen;
        logic [31:0] d;
        logic        e;
        do_reset();
        model_default();
        resp_delay[0] = 2;
        resp_data[0]  = 32'h1111_2222;
        apb_write(32'h04, 32'd20);
        apb_write(32'h00, 32'h0000_0101);
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge PCLK);
            if (poll_req[0]) begin
                seen = 1'b1;
                break;
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL w1c_wait: poll_req[0] seen=0 required 1");
        end
        // Access phase lands on the edge where poll_done[0] is high.
        apb_write(32'h08, 32'h0000_0001);
        apb_write(32'h00, 32'h0000_0100);
        apb_read(32'h08, d, e);
        checks++;
        if (d[0] !== 1'b1) begin
            errors++;
            $display("FAIL w1c_set_wins: status %h bit0=%b required 1", d, d[0]);
        end
        apb_read(32'h10, d, e);
        checks++;
        if (d !== 32'h1111_2222) begin
            errors++;
            $display("FAIL w1c_data0: read %h required 11112222", d);
        end
        apb_write(32'h08, 32'h0000_0001);
        apb_read(32'h08, d, e);
        checks++;
        if (d[0] !== 1'b0) begin
            errors++;
            $display("FAIL w1c_clear: status %h bit0=%b required 0", d, d[0]);
        end
    endtask

    task automatic test_ctrl_reset();
        int          snap;
        logic [31:0] d;
        logic        e;
        do_reset();
        snap = creset_cycles;
        apb_write(32'h00, 32'h0000_0F02);
        repeat (3) @(negedge PCLK);
        checks++;
        if (creset_cycles - snap != 1 || creset_seen !== 4'hF) begin
            errors++;
            $display("FAIL creset_pulse: cycles=%0d value=%h required 1 f", creset_cycles - snap, creset_seen);
        end
        apb_read(32'h00, d, e);
        checks++;
        if (d !== 32'h0000_0F00 || e !== 1'b0) begin
            errors++;
            $display("FAIL ctrl_readback: read %h err %b required 00000f00 err 0", d, e);
        end
        apb_read(32'h40, d, e);
        checks++;
        if (d !== 32'h0 || e !== 1'b1) begin
            errors++;
            $display("FAIL unmapped_read: read %h err %b required 00000000 err 1", d, e);
        end
        apb_write(32'h40, 32'hFFFF_FFFF);
        apb_read(32'h00, d, e);
        checks++;
        if (d !== 32'h0000_0F00) begin
            errors++;
            $display("FAIL unmapped_write: ctrl %h required 00000f00", d);
        end
    endtask

    task automatic test_change_detect();
        int          snap0;
        bit          ok;
        logic [31:0] d;
        logic        e;
        logic        exp_second;
`ifdef N64_CHANGE_DETECT_EN
        exp_second = 1'b0;
`else
        exp_second = 1'b1;
`endif
        do_reset();
        model_default();
        resp_delay[0] = 3;
        resp_data[0]  = 32'h1234_5678;
        snap0 = req_count[0];
        apb_write(32'h04, 32'd40);
        apb_write(32'h00, 32'h0000_0101);
        wait_reqs(0, snap0 + 1, 200, ok);
        repeat (8) @(negedge PCLK);
        apb_read(32'h08, d, e);
        checks++;
        if (!ok || d[0] !== 1'b1) begin
            errors++;
            $display("FAIL change_first: polled=%b new_data=%b required 1 1", ok, d[0]);
        end
        apb_write(32'h08, 32'h0000_0001);
        wait_reqs(0, snap0 + 2, 200, ok);
        repeat (8) @(negedge PCLK);
        apb_write(32'h00, 32'h0000_0100);
        apb_read(32'h08, d, e);
        checks++;
        if (!ok || d[0] !== exp_second) begin
            errors++;
            $display("FAIL change_second: polled=%b new_data=%b required 1 %b", ok, d[0], exp_second);
        end
        apb_read(32'h10, d, e);
        checks++;
        if (d !== 32'h1234_5678) begin
            errors++;
            $display("FAIL change_data0: read %h required 12345678", d);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at 2ms required finished");
        $fatal(1, "watchdog");
    end

    initial begin
        model_default();
        test_reset();
        test_sweep();
        test_timeout();
        test_overrun();
        test_w1c_collision();
        test_ctrl_reset();
        test_change_detect();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
